// File: rtl/trigger_capture.sv
// ============================================================================
// Module      : trigger_capture
// Description : Circular sample recorder with slope/level trigger that freezes
//               a DEPTH-sample frame holding PRE_TRIG pre-trigger samples.
//               Optional macro TRIG_HYST_EN selects the hysteresis trigger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_capture #(
  parameter int DATA_W   = 12,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 32,
  parameter int HYST     = 8,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              arm,
  output logic              busy,
  output logic              frame_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] PRE_CNT  = (ADDR_W+1)'(PRE_TRIG);
  localparam logic [ADDR_W:0] POST_CNT = (ADDR_W+1)'(DEPTH - PRE_TRIG);
  localparam state_t          FIRST_ST = (PRE_TRIG == 0) ? S_WAIT : S_PRE;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              we;
  logic              trig_hit;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] rd_phys;

`ifdef TRIG_HYST_EN
  localparam logic [DATA_W:0] HYST_EXT = (DATA_W+1)'(HYST);
  localparam logic [DATA_W:0] CODE_MAX = (DATA_W+1)'((1 << DATA_W) - 1);

  logic            hyst_armed_q, hyst_armed_d;
  logic [DATA_W:0] lvl_ext, lo_thr, hi_sum, hi_thr;
  logic            rearm;

  always_comb begin
    lvl_ext  = {1'b0, trig_level};
    lo_thr   = (lvl_ext >= HYST_EXT) ? (lvl_ext - HYST_EXT) : '0;
    hi_sum   = lvl_ext + HYST_EXT;
    hi_thr   = (hi_sum > CODE_MAX) ? CODE_MAX : hi_sum;
    rearm    = trig_slope ? ({1'b0, sample_in} > hi_thr) : ({1'b0, sample_in} < lo_thr);
    trig_hit = hyst_armed_q &&
               (trig_slope ? (sample_in <= trig_level) : (sample_in >= trig_level));
  end
`else
  always_comb begin
    trig_hit = prev_valid_q &&
               (trig_slope ? (prev_q > trig_level && sample_in <= trig_level)
                           : (prev_q < trig_level && sample_in >= trig_level));
  end
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    trig_ptr_d   = trig_ptr_q;
    we           = 1'b0;
    cnt_inc      = cnt_q + 1'b1;
`ifdef TRIG_HYST_EN
    hyst_armed_d = hyst_armed_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d      = FIRST_ST;
          wr_ptr_d     = '0;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
`ifdef TRIG_HYST_EN
          hyst_armed_d = 1'b0;
`endif
        end
      end
      S_PRE: begin
        if (sample_valid) begin
          we           = 1'b1;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          cnt_d        = cnt_inc;
          prev_d       = sample_in;
          prev_valid_d = 1'b1;
`ifdef TRIG_HYST_EN
          if (rearm) hyst_armed_d = 1'b1;
`endif
          if (cnt_inc == PRE_CNT) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sample_valid) begin
          we           = 1'b1;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          prev_d       = sample_in;
          prev_valid_d = 1'b1;
          if (trig_hit) begin
            // The trigger sample itself is the first of the post-trigger run
            trig_ptr_d = wr_ptr_q;
            cnt_d      = (ADDR_W+1)'(1);
            state_d    = (POST_CNT == (ADDR_W+1)'(1)) ? S_DONE : S_POST;
`ifdef TRIG_HYST_EN
            hyst_armed_d = 1'b0;
          end else if (rearm) begin
            hyst_armed_d = 1'b1;
`endif
          end
        end
      end
      S_POST: begin
        if (sample_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == POST_CNT) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_phys   = trig_ptr_q - ADDR_W'(PRE_TRIG) + rd_addr;
    rd_data_d = mem[rd_phys];
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      trig_ptr_q   <= '0;
      rd_data_q    <= '0;
`ifdef TRIG_HYST_EN
      hyst_armed_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      trig_ptr_q   <= trig_ptr_d;
      rd_data_q    <= rd_data_d;
`ifdef TRIG_HYST_EN
      hyst_armed_q <= hyst_armed_d;
`endif
    end
  end

  assign busy        = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign frame_ready = (state_q == S_DONE);
  assign rd_data     = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_trigger_capture.sv
// ============================================================================
// Module      : tb_trigger_capture
// Description : Scoreboard bench for trigger_capture; expected frame samples
//               are queued as the stream is driven and popped on readout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trigger_capture;

  localparam int DATA_W   = 12;
  localparam int DEPTH    = 256;
  localparam int PRE_TRIG = 32;
  localparam int HYST     = 8;
  localparam int ADDR_W   = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic              arm;
  logic              busy;
  logic              frame_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int hist[0:4095];

  trigger_capture #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .PRE_TRIG(PRE_TRIG),
    .HYST    (HYST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .arm         (arm),
    .busy        (busy),
    .frame_ready (frame_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int stim(input int scen, input int i);
    case (scen)
      1:       return (16 * i) % 4096;
      2:       return (4095 - 16 * i) & 4095;
      3:       return (i % 2 == 1) ? 2052 : 2044;
      default: return 100;
    endcase
  endfunction

  // Arms, streams samples and queues the frame the reference trigger predicts
  task automatic run_capture(input int scen, input int level, input bit slope,
                             input bit gaps, input bit arm_post, input int max_samples);
    int  k, t, pushed, v;
    bit  hit, done, m_armed;
    trig_level = DATA_W'(level);
    trig_slope = slope;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_val("busy_after_arm", busy, 1);
    k = 0; t = -1; pushed = 0; done = 1'b0; m_armed = 1'b0;
    while (!done && k < max_samples) begin
      v = stim(scen, k);
      hist[k] = v;
      if (t < 0) begin
        hit = 1'b0;
        if (k >= PRE_TRIG) begin
`ifdef TRIG_HYST_EN
          hit = m_armed && (slope ? (v <= level) : (v >= level));
`else
          hit = (k > 0) && (slope ? (hist[k-1] > level && v <= level)
                                  : (hist[k-1] < level && v >= level));
`endif
        end
        if (!hit) begin
          if (slope ? (v > ((level + HYST > 4095) ? 4095 : level + HYST))
                    : (v < ((level - HYST < 0) ? 0 : level - HYST)))
            m_armed = 1'b1;
        end
        if (hit) begin
          t = k;
          for (int j = k - PRE_TRIG; j <= k; j++) exp_q.push_back(hist[j]);
          pushed = PRE_TRIG + 1;
        end
      end else begin
        exp_q.push_back(v);
        pushed++;
      end
      if (pushed == DEPTH) done = 1'b1;
      arm          = arm_post && (t >= 0) && (pushed == 40 || done);
      sample_in    = DATA_W'(v);
      sample_valid = 1'b1;
      tick();
      arm          = 1'b0;
      sample_valid = 1'b0;
      check_val("frame_ready", frame_ready, int'(done));
      if (gaps) begin
        tick();
        check_val("busy_gap", busy, int'(!done));
      end
      k++;
    end
  endtask

  task automatic read_frame();
    int e;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = ADDR_W'(a);
      tick();
      if (exp_q.size() == 0) begin
        check_val("sb_empty", 1, 0);
        return;
      end
      e = exp_q.pop_front();
      check_val("rd_data", rd_data, e);
    end
  endtask

  task automatic spot(input string tag, input int a, input int exp);
    rd_addr = ADDR_W'(a);
    tick();
    check_val(tag, rd_data, exp);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; sample_in = '0; sample_valid = 1'b0; trig_level = '0;
    trig_slope = 1'b0; arm = 1'b0; rd_addr = '0;
    tick(); tick();
    check_val("rst_busy", busy, 0);
    check_val("rst_frame_ready", frame_ready, 0);
    check_val("rst_rd_data", rd_data, 0);
    rst = 1'b1;
    tick();

    // Rising ramp
    run_capture(1, 2048, 1'b0, 1'b0, 1'b0, 1000);
    read_frame();
    spot("ramp_trig", 32, 2048);
    spot("ramp_oldest", 0, 1536);
    spot("ramp_newest", 255, 1520);

    // Falling ramp
    run_capture(2, 1000, 1'b1, 1'b0, 1'b0, 1000);
    read_frame();
    spot("fall_trig", 32, 991);

    // Noise around the level
    run_capture(3, 2048, 1'b0, 1'b0, 1'b0, 300);
    if (exp_q.size() == 0) begin
      check_val("noise_busy", busy, 1);
      pulse_reset();
      check_val("noise_abort_busy", busy, 0);
    end else begin
      read_frame();
    end

    // Valid gaps during acquisition
    run_capture(1, 2048, 1'b0, 1'b1, 1'b0, 1000);
    read_frame();
    spot("gap_trig", 32, 2048);

    // Reset while waiting for a trigger
    run_capture(4, 2048, 1'b0, 1'b0, 1'b0, 40);
    check_val("wait_busy", busy, 1);
    pulse_reset();
    check_val("abort_busy", busy, 0);
    check_val("abort_frame_ready", frame_ready, 0);
    check_val("abort_rd_data", rd_data, 0);
    run_capture(1, 2048, 1'b0, 1'b0, 1'b0, 1000);
    read_frame();

    // arm during POST and on the final sample is ignored; arm in DONE restarts
    run_capture(1, 2048, 1'b0, 1'b0, 1'b1, 1000);
    read_frame();
    check_val("done_frame_ready", frame_ready, 1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_val("rearm_frame_ready", frame_ready, 0);
    check_val("rearm_busy", busy, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
